// File: rtl/rgmii_tx.sv
// RGMII transmit framer: preamble/SFD insert, optional pad + CRC-32 (RGMII_TX_FCS_EN), IFG enforcement.
// Latency: beat accepted in cycle n is on the rgmii_* outputs in cycle n+1; all outputs registered.
// Backpressure: mac_ready only in S_SFD/S_DATA (plus stray non-SOP discard in S_IDLE); valid drop mid-frame aborts.
module rgmii_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst,
    input  logic                  mac_startofpacket,
    input  logic                  mac_endofpacket,
    input  logic                  mac_valid,
    input  logic [DATA_WIDTH-1:0] mac_data,
    input  logic                  mac_error,
    output logic                  mac_ready,
    output logic [3:0]            rgmii_txd_rise,
    output logic [3:0]            rgmii_txd_fall,
    output logic                  rgmii_ctl_rise,
    output logic                  rgmii_ctl_fall,
    output logic                  tx_frame_done,
    output logic                  tx_underrun
);

`ifdef RGMII_TX_FCS_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_PREAMBLE = 3'd1, S_SFD = 3'd2, S_DATA = 3'd3,
        S_PAD = 3'd4, S_FCS = 3'd5, S_IFG = 3'd6
    } state_t;

    localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [31:0] crc_q, crc_d, crc_fin;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_PREAMBLE = 3'd1, S_SFD = 3'd2, S_DATA = 3'd3, S_IFG = 3'd6
    } state_t;
`endif

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

    state_t      state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d, cnt_inc;
    logic [7:0]  ph_cnt_q, ph_cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d, er_q, er_d;
    logic        done_q, done_d, unr_q, unr_d;

    assign cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

    // The combinational block decides what the wire shows in the next cycle.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        er_d       = 1'b0;
        done_d     = 1'b0;
        unr_d      = 1'b0;
        mac_ready  = 1'b0;
`ifdef RGMII_TX_FCS_EN
        crc_d      = crc_q;
        crc_fin    = ~crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                mac_ready = mac_valid & ~mac_startofpacket;
                if (mac_valid && mac_startofpacket) begin
                    state_d    = S_PREAMBLE;
                    ph_cnt_d   = 8'd0;
                    byte_cnt_d = 16'd0;
                    txd_d      = 8'h55;
                    en_d       = 1'b1;
`ifdef RGMII_TX_FCS_EN
                    crc_d      = 32'hFFFFFFFF;
`endif
                end
            end
            S_PREAMBLE: begin
                en_d = 1'b1;
                if (ph_cnt_q == PRE_LAST) begin
                    txd_d   = 8'hD5;
                    state_d = S_SFD;
                end else begin
                    txd_d    = 8'h55;
                    ph_cnt_d = ph_cnt_q + 8'd1;
                end
            end
            S_SFD, S_DATA: begin
                mac_ready = 1'b1;
                en_d      = 1'b1;
                ph_cnt_d  = 8'd0;
                if (mac_valid) begin
                    txd_d      = mac_data;
                    er_d       = mac_error;
                    byte_cnt_d = cnt_inc;
                    state_d    = S_DATA;
`ifdef RGMII_TX_FCS_EN
                    crc_d      = crc_byte(crc_q, mac_data);
                    if (mac_endofpacket) begin
                        state_d = (cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
                    end
`else
                    if (mac_endofpacket) begin
                        state_d = S_IFG;
                        done_d  = 1'b1;
                    end
`endif
                end else begin
                    // Underrun: one errored filler byte, then straight to the gap.
                    er_d    = 1'b1;
                    unr_d   = 1'b1;
                    state_d = S_IFG;
                end
            end
`ifdef RGMII_TX_FCS_EN
            S_PAD: begin
                en_d       = 1'b1;
                byte_cnt_d = cnt_inc;
                crc_d      = crc_byte(crc_q, 8'h00);
                if (cnt_inc >= MIN_CNT) begin
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                en_d     = 1'b1;
                ph_cnt_d = ph_cnt_q + 8'd1;
                case (ph_cnt_q[1:0])
                    2'd0:    txd_d = crc_fin[7:0];
                    2'd1:    txd_d = crc_fin[15:8];
                    2'd2:    txd_d = crc_fin[23:16];
                    default: txd_d = crc_fin[31:24];
                endcase
                if (ph_cnt_q[1:0] == 2'd3) begin
                    state_d  = S_IFG;
                    ph_cnt_d = 8'd0;
                    done_d   = 1'b1;
                end
            end
`endif
            S_IFG: begin
                ph_cnt_d = ph_cnt_q + 8'd1;
                if (ph_cnt_q == IFG_LAST) begin
                    state_d  = S_IDLE;
                    ph_cnt_d = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 16'd0;
            ph_cnt_q   <= 8'd0;
            txd_q      <= 8'h00;
            en_q       <= 1'b0;
            er_q       <= 1'b0;
            done_q     <= 1'b0;
            unr_q      <= 1'b0;
`ifdef RGMII_TX_FCS_EN
            crc_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            txd_q      <= txd_d;
            en_q       <= en_d;
            er_q       <= er_d;
            done_q     <= done_d;
            unr_q      <= unr_d;
`ifdef RGMII_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign rgmii_txd_rise = txd_q[3:0];
    assign rgmii_txd_fall = txd_q[7:4];
    assign rgmii_ctl_rise = en_q;
    assign rgmii_ctl_fall = en_q ^ er_q;
    assign tx_frame_done  = done_q;
    assign tx_underrun    = unr_q;

endmodule

// File: tb/tb_rgmii_tx.sv
// Scoreboard bench for rgmii_tx: two instances (MIN_FRAME 0 and 60) share stimulus, sel picks the one observed.
module tb_rgmii_tx;

`ifdef RGMII_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic       mac_clk = 1'b0;
    logic       mac_rst, sop, eop, valid, err, sel;
    logic [7:0] data;

    logic       rdy0, cr0, cf0, dn0, un0, rdy1, cr1, cf1, dn1, un1;
    logic [3:0] tr0, tf0, tr1, tf1;
    logic       m_ready, m_en, m_ctlf, m_done, m_unr;
    logic [3:0] m_txr, m_txf;

    always #4 mac_clk = ~mac_clk;

    rgmii_tx #(.MIN_FRAME(0)) u_dut0 (
        .mac_clk(mac_clk), .mac_rst(mac_rst), .mac_startofpacket(sop), .mac_endofpacket(eop),
        .mac_valid(valid), .mac_data(data), .mac_error(err), .mac_ready(rdy0),
        .rgmii_txd_rise(tr0), .rgmii_txd_fall(tf0), .rgmii_ctl_rise(cr0), .rgmii_ctl_fall(cf0),
        .tx_frame_done(dn0), .tx_underrun(un0));

    rgmii_tx #(.MIN_FRAME(60)) u_dut60 (
        .mac_clk(mac_clk), .mac_rst(mac_rst), .mac_startofpacket(sop), .mac_endofpacket(eop),
        .mac_valid(valid), .mac_data(data), .mac_error(err), .mac_ready(rdy1),
        .rgmii_txd_rise(tr1), .rgmii_txd_fall(tf1), .rgmii_ctl_rise(cr1), .rgmii_ctl_fall(cf1),
        .tx_frame_done(dn1), .tx_underrun(un1));

    assign m_ready = sel ? rdy1 : rdy0;
    assign m_en    = sel ? cr1  : cr0;
    assign m_ctlf  = sel ? cf1  : cf0;
    assign m_done  = sel ? dn1  : dn0;
    assign m_unr   = sel ? un1  : un0;
    assign m_txr   = sel ? tr1  : tr0;
    assign m_txf   = sel ? tf1  : tf0;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];
    int exp_run_q[$];
    int exp_gap_q[$];
    int run = 0, gap = 0, done_seen = 0, unr_seen = 0;
    logic prev_en = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every TX_EN cycle consumes one expected {er, byte} entry.
    always @(negedge mac_clk) begin
        logic [8:0] e;
        if (m_done) done_seen++;
        if (m_unr)  unr_seen++;
        if (valid && sop && !m_en) check("ready_while_sop_waits", int'(m_ready), 0);
        if (m_en) begin
            if (!prev_en && exp_gap_q.size() > 0) check("ifg_gap", gap, exp_gap_q.pop_front());
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %0h with TX_EN, none expected", {m_txf, m_txr});
            end else begin
                e = exp_q.pop_front();
                check("txd", int'({m_txf, m_txr}), int'(e[7:0]));
                check("ctl_fall", int'(m_ctlf), e[8] ? 0 : 1);
            end
            run++;
            gap = 0;
        end else begin
            if (prev_en && exp_run_q.size() > 0) check("tx_en_len", run, exp_run_q.pop_front());
            run = 0;
            gap++;
        end
        prev_en = m_en;
    end

    function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic push_b(input logic [7:0] v, input bit er);
        exp_q.push_back({er, v});
    endtask

    task automatic push_hdr();
        for (int i = 0; i < 7; i++) push_b(8'h55, 1'b0);
        push_b(8'hD5, 1'b0);
    endtask

    task automatic expect_frame(input logic [7:0] b[$], input int err_idx, input int minf);
        logic [7:0] all[$];
        logic [31:0] c;
        int n;
        push_hdr();
        n = 8;
        foreach (b[i]) begin
            push_b(b[i], i == err_idx);
            all.push_back(b[i]);
            n++;
        end
        if (FCS_ON) begin
            while (all.size() < minf) begin
                all.push_back(8'h00);
                push_b(8'h00, 1'b0);
                n++;
            end
            c = crc32_ref(all);
            for (int k = 0; k < 4; k++) push_b(c[8*k +: 8], 1'b0);
            n += 4;
        end
        exp_run_q.push_back(n);
    endtask

    task automatic drive_beat(input logic [7:0] d, input bit s, input bit e, input bit er);
        int  n;
        bit  acc;
        valid = 1'b1; data = d; sop = s; eop = e; err = er;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge mac_clk);
            acc = m_ready;
            @(posedge mac_clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: ready not seen for byte %0h, required within 300 cycles", d);
        end
    endtask

    task automatic send_frame(input logic [7:0] b[$], input int err_idx);
        for (int i = 0; i < b.size(); i++)
            drive_beat(b[i], i == 0, i == b.size() - 1, i == err_idx);
        valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge mac_clk);
        #1;
    endtask

    task automatic do_reset();
        mac_rst = 1'b1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
        repeat (2) @(posedge mac_clk);
        #1 mac_rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] fb[$];
        int d0, u0;
        sel = 1'b0; mac_rst = 1'b1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; data = 8'h00;
        repeat (2) @(posedge mac_clk);
        @(negedge mac_clk);
        check("rst_txd", int'({m_txf, m_txr}), 0);
        check("rst_ctl", int'({m_en, m_ctlf}), 0);
        check("rst_pulses", int'({m_done, m_unr}), 0);
        check("rst_ready", int'(m_ready), 0);
        @(posedge mac_clk);
        #1 mac_rst = 1'b0;
        idle(3);

        // "123456789": CRC-32 is CBF43926, sent LSB first.
        d0 = done_seen; u0 = unr_seen;
        fr = {};
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
        push_hdr();
        foreach (fr[i]) push_b(fr[i], 1'b0);
        if (FCS_ON) begin
            push_b(8'h26, 1'b0); push_b(8'h39, 1'b0); push_b(8'hF4, 1'b0); push_b(8'hCB, 1'b0);
        end
        exp_run_q.push_back(FCS_ON ? 21 : 17);
        send_frame(fr, -1);
        idle(40);
        check("check_str_done", done_seen - d0, 1);
        check("check_str_unr", unr_seen - u0, 0);

        // Back-to-back: second SOP held valid through the whole gap.
        d0 = done_seen;
        fr = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        fb = {8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        expect_frame(fr, -1, 0);
        send_frame(fr, -1);
        exp_gap_q.push_back(12);
        expect_frame(fb, -1, 0);
        send_frame(fb, -1);
        idle(40);
        check("b2b_done", done_seen - d0, 2);
        check("b2b_gap_consumed", exp_gap_q.size(), 0);

        // Errored beat 3 only.
        d0 = done_seen;
        fr = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        expect_frame(fr, 2, 0);
        send_frame(fr, 2);
        idle(40);
        check("err_done", done_seen - d0, 1);

        // 5-byte frame (13 TX_EN cycles without FCS).
        fr = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        expect_frame(fr, -1, 0);
        send_frame(fr, -1);
        idle(40);

        // Reset during S_DATA after three accepted beats.
        d0 = done_seen; u0 = unr_seen;
        push_hdr();
        push_b(8'hC0, 1'b0); push_b(8'hC1, 1'b0); push_b(8'hC2, 1'b0);
        exp_run_q.push_back(11);
        drive_beat(8'hC0, 1'b1, 1'b0, 1'b0);
        drive_beat(8'hC1, 1'b0, 1'b0, 1'b0);
        drive_beat(8'hC2, 1'b0, 1'b0, 1'b0);
        mac_rst = 1'b1; valid = 1'b0; sop = 1'b0;
        @(posedge mac_clk);
        @(negedge mac_clk);
        check("midrst_txd", int'({m_txf, m_txr}), 0);
        check("midrst_ctl", int'({m_en, m_ctlf}), 0);
        check("midrst_ready", int'(m_ready), 0);
        @(posedge mac_clk);
        #1 mac_rst = 1'b0;
        idle(2);
        fr = {8'h5A, 8'hA5, 8'h3C};
        expect_frame(fr, -1, 0);
        send_frame(fr, -1);
        idle(40);
        check("midrst_done", done_seen - d0, 1);
        check("midrst_unr", unr_seen - u0, 0);

        // MIN_FRAME=60 instance: 10-byte payload padded with 50 zero bytes.
        sel = 1'b1;
        do_reset();
        idle(2);
        d0 = done_seen;
        fr = {};
        for (int i = 1; i <= 10; i++) fr.push_back(8'(i));
        expect_frame(fr, -1, 60);
        send_frame(fr, -1);
        idle(100);
        check("pad_done", done_seen - d0, 1);

        // Underrun on beat 5 of a 20-byte frame: no pad, no FCS, no done.
        d0 = done_seen; u0 = unr_seen;
        push_hdr();
        for (int i = 0; i < 4; i++) push_b(8'h80 + 8'(i), 1'b0);
        push_b(8'h00, 1'b1);
        exp_run_q.push_back(13);
        for (int i = 0; i < 4; i++) drive_beat(8'h80 + 8'(i), i == 0, 1'b0, 1'b0);
        valid = 1'b0; sop = 1'b0;
        idle(40);
        check("unr_pulse", unr_seen - u0, 1);
        check("unr_no_done", done_seen - d0, 0);

        check("exp_bytes_left", exp_q.size(), 0);
        check("exp_runs_left", exp_run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgmii_tx.md
Name: rgmii_tx

Overview:
- Transmit framer and RGMII driver for the MAC datapath.
- Accepts frames on the mac_clk streaming interface (sop/eop/valid/ready/error) and prepends preamble and SFD.
- Optionally pads short frames and appends FCS, then enforces the inter-frame gap.
- Drives pre-split rise/fall nibbles and ctl bits to external DDR output primitives; single clock domain, no FIFO.

Parameters:
- DATA_WIDTH, 8, streaming data width; only 8 is supported.
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD.
- MIN_FRAME, 60, minimum byte count before FCS; 0 disables padding.
- IFG_BYTES, 12, idle byte times after each frame.

Ports:
- mac_clk  in  1  125 MHz byte clock; also the RGMII TX clock source.
- mac_rst  in  1  synchronous reset, active-high.
- mac_startofpacket  in  1  first beat of frame.
- mac_endofpacket  in  1  last beat of frame.
- mac_valid  in  1  beat valid.
- mac_data  in  DATA_WIDTH  frame byte (destination MAC first).
- mac_error  in  1  force error on this byte.
- mac_ready  out  1  beat accepted when valid & ready.
- rgmii_txd_rise  out  4  byte[3:0], rising-edge nibble.
- rgmii_txd_fall  out  4  byte[7:4], falling-edge nibble.
- rgmii_ctl_rise  out  1  TX_EN.
- rgmii_ctl_fall  out  1  TX_EN xor TX_ER.
- tx_frame_done  out  1  one-cycle pulse after last frame byte leaves.
- tx_underrun  out  1  one-cycle pulse on underrun abort.

Behaviour:
- Reset: all outputs registered and 0 (mac_ready 0), state S_IDLE, counters 0. Reset mid-frame takes effect on the next edge; outputs go idle immediately and the frame is not completed.
- States: S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG.
- S_IDLE:
  - mac_ready = mac_valid & ~mac_startofpacket, so stray non-SOP beats are discarded.
  - A valid SOP beat is held (not accepted) and the block moves to S_PREAMBLE.
- S_PREAMBLE: outputs 0x55 with TX_EN=1 for PREAMBLE_LEN cycles, then S_SFD.
- S_SFD:
  - Outputs 0xD5 with mac_ready=1, so the SOP beat is accepted this cycle.
  - Goes to S_DATA.
- S_DATA:
  - mac_ready=1. A beat accepted in cycle n appears on the outputs in cycle n+1.
  - mac_error=1 on a beat sets TX_ER for that byte: ctl_fall = 0 while ctl_rise = 1.
  - Accepting eop moves to S_PAD if the byte count is below MIN_FRAME (FCS enabled), else S_FCS (enabled), else S_IFG.
  - A SOP arriving mid-frame is treated as a data byte, not a new frame.
- Underrun: mac_valid=0 in S_SFD or S_DATA.
  - Emit one byte 0x00 with TX_EN=1, TX_ER=1.
  - Pulse tx_underrun, skip pad/FCS, go to S_IFG.
- S_PAD: outputs 0x00 until count reaches MIN_FRAME, then S_FCS.
- S_FCS: 4 bytes of CRC-32 (then S_IFG).
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
  - Covers data and pad bytes; sent LSB byte first.
- S_IFG:
  - tx_frame_done pulses on the first cycle; suppressed if the frame aborted on underrun.
  - Outputs idle (data 0, ctl 0) for IFG_BYTES cycles, then S_IDLE.
  - A SOP presented during IFG waits; mac_ready stays 0.
- Byte counter: 16 bits, saturates at 0xFFFF; no jumbo limit is enforced.
- All outputs are registered; there are no combinational paths from inputs to rgmii_* outputs. mac_ready is decoded from state plus mac_valid/mac_startofpacket only.

Optional Feature:
- Macro RGMII_TX_FCS_EN.
- Defined: S_PAD and S_FCS are present, with padding to MIN_FRAME and the CRC-32 append.
- Undefined:
  - The frame is sent verbatim: no pad and no FCS, and S_PAD/S_FCS/CRC logic is not compiled.
  - eop goes directly to S_IFG; upstream supplies FCS and minimum length.

Test Plan:
- FCS on, MIN_FRAME=0:
  - Stimulus: send ASCII "123456789" (9 beats).
  - Required response: wire shows 7x55, D5, 31..39, then FCS bytes 26 39 F4 CB; TX_EN high for exactly 21 cycles; 12 idle cycles; tx_frame_done one pulse.
- FCS on, MIN_FRAME=60:
  - Stimulus: 10-byte payload 01..0A.
  - Required response: 50 bytes of 00 pad, FCS, TX_EN high for 72 cycles.
- Back-to-back frames with SOP held valid during IFG:
  - Required response: exactly 12 cycles between TX_EN falling and the next preamble; mac_ready 0 throughout IFG.
- Underrun: deassert mac_valid on beat 5 of a 20-byte frame.
  - Required response: one byte with ctl_rise=1/ctl_fall=0, tx_underrun pulse, no FCS, no tx_frame_done, then IFG.
- mac_error on beat 3:
  - Required response: only that byte has ctl_fall=0; the frame otherwise completes normally.
- mac_rst asserted during S_DATA:
  - Required response: next cycle all outputs 0, mac_ready 0; a following frame transmits correctly.
- Build without RGMII_TX_FCS_EN:
  - Stimulus: 5-byte frame.
  - Required response: TX_EN high for 13 cycles; no pad or FCS bytes.
